// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP video pipeline.
package dvp_pkg;

    localparam int unsigned PIX_W = 16;
    localparam int unsigned CNT_W = 12;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // One FIFO entry: sideband flags above the packed pixel (18 bits total).
    typedef struct packed {
        logic             tuser;
        logic             tlast;
        logic [PIX_W-1:0] tdata;
    } pix_word_t;

    // Geometry counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock show-ahead FIFO; depth 2**AW words, synchronous active-high reset.
module axis_sync_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned W  = 18
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_wr, do_rd;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd     = rd_en_i & ~empty_o;
    // A write into a full FIFO is still taken when a read frees a slot this cycle.
    assign do_wr     = wr_en_i & (~full_o | do_rd);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/dvp_pixel_packer.sv
// Packs DVP byte pairs into 16-bit pixels, buffers them, measures geometry, flags errors.
module dvp_pixel_packer
    import dvp_pkg::*;
#(
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned FIFO_AW   = 2,
    parameter int unsigned H_PIXELS  = 640,
    parameter int unsigned V_LINES   = 480
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    input  logic             s_tuser,
    output logic [PIX_W-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tuser,
    input  logic             clr_err,
    output logic             overflow,
    output logic             align_err,
    output logic             width_err,
    output logic             height_err,
    output logic [CNT_W-1:0] last_width,
    output logic [CNT_W-1:0] last_height,
    output logic [15:0]      frame_cnt
);

    localparam logic [CNT_W-1:0] H_CHK = CNT_W'(H_PIXELS);
    localparam logic [CNT_W-1:0] V_CHK = CNT_W'(V_LINES);

    logic             phase_q, phase_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_user_q, hold_user_d;
    logic             first_frame_q, first_frame_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] last_width_q, last_width_d;
    logic [CNT_W-1:0] last_height_q, last_height_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             overflow_q, overflow_d;
    logic             align_err_q, align_err_d;
    logic             width_err_q, width_err_d;
    logic             height_err_q, height_err_d;

    logic      sof, second_byte, form, pop, push_drop;
    logic      fifo_full, fifo_empty;
    pix_word_t push_word, head_word;

    assign sof         = s_tvalid & s_tuser;
    // An SOF byte always restarts pairing, so it can never complete a pixel.
    assign second_byte = phase_q & ~s_tuser;
    assign form        = s_tvalid & second_byte;
    assign pop         = m_tvalid & m_tready;
    assign push_drop   = form & fifo_full & ~pop;

    assign push_word.tuser = hold_user_q;
    assign push_word.tlast = s_tlast;
    assign push_word.tdata = MSB_FIRST ? {hold_q, s_tdata} : {s_tdata, hold_q};

    axis_sync_fifo #(
        .AW (FIFO_AW),
        .W  ($bits(pix_word_t))
    ) u_fifo (
        .clk_i     (pclk),
        .rst_i     (rst),
        .wr_en_i   (form),
        .wr_data_i (push_word),
        .rd_en_i   (pop),
        .rd_data_o (head_word),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Outputs read as zero while nothing is buffered, so reset shows all-zero.
    assign m_tvalid    = ~fifo_empty;
    assign m_tdata     = fifo_empty ? '0 : head_word.tdata;
    assign m_tlast     = ~fifo_empty & head_word.tlast;
    assign m_tuser     = ~fifo_empty & head_word.tuser;
    assign overflow    = overflow_q;
    assign align_err   = align_err_q;
    assign width_err   = width_err_q;
    assign height_err  = height_err_q;
    assign last_width  = last_width_q;
    assign last_height = last_height_q;
    assign frame_cnt   = frame_cnt_q;

    // Byte pairing, geometry counters and sticky error next-state.
    always_comb begin
        phase_d       = phase_q;
        hold_d        = hold_q;
        hold_user_d   = hold_user_q;
        first_frame_d = first_frame_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        last_width_d  = last_width_q;
        last_height_d = last_height_q;
        frame_cnt_d   = frame_cnt_q;
        // Clear first so an error arriving with clr_err still sets the flag.
        overflow_d    = overflow_q & ~clr_err;
        align_err_d   = align_err_q & ~clr_err;
        width_err_d   = width_err_q & ~clr_err;
        height_err_d  = height_err_q & ~clr_err;

        if (sof) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (!first_frame_q) begin
                last_height_d = line_cnt_q;
                if (line_cnt_q != V_CHK) height_err_d = 1'b1;
            end
            first_frame_d = 1'b0;
            pix_cnt_d     = '0;
            line_cnt_d    = '0;
            if (phase_q) align_err_d = 1'b1;
        end

        if (s_tvalid) begin
            if (second_byte) begin
                phase_d   = 1'b0;
                pix_cnt_d = sat_inc(pix_cnt_d);
                if (push_drop) overflow_d = 1'b1;
            end else if (s_tlast) begin
                // Lone byte at end of line: dropped, but the line still closes below.
                phase_d     = 1'b0;
                align_err_d = 1'b1;
            end else begin
                phase_d     = 1'b1;
                hold_d      = s_tdata;
                hold_user_d = s_tuser;
            end

            if (s_tlast) begin
                last_width_d = pix_cnt_d;
                if (pix_cnt_d != H_CHK) width_err_d = 1'b1;
                pix_cnt_d  = '0;
                line_cnt_d = sat_inc(line_cnt_d);
            end
        end
    end

    // State registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            phase_q       <= 1'b0;
            hold_q        <= '0;
            hold_user_q   <= 1'b0;
            first_frame_q <= 1'b1;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            last_width_q  <= '0;
            last_height_q <= '0;
            frame_cnt_q   <= '0;
            overflow_q    <= 1'b0;
            align_err_q   <= 1'b0;
            width_err_q   <= 1'b0;
            height_err_q  <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            hold_q        <= hold_d;
            hold_user_q   <= hold_user_d;
            first_frame_q <= first_frame_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            last_width_q  <= last_width_d;
            last_height_q <= last_height_d;
            frame_cnt_q   <= frame_cnt_d;
            overflow_q    <= overflow_d;
            align_err_q   <= align_err_d;
            width_err_q   <= width_err_d;
            height_err_q  <= height_err_d;
        end
    end

endmodule

// File: tb/tb_dvp_pixel_packer.sv
// Self-checking bench: two packers (MSB-first and LSB-first) share one byte stream and
// are compared every cycle against a queue-based reference model.
module tb_dvp_pixel_packer;

    localparam int unsigned FIFO_AW = 2;
    localparam int          DEPTH   = 4;
    localparam int          H_PIX   = 4;
    localparam int          V_LIN   = 3;

    logic        pclk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tuser;
    logic        m_tready, clr_err;

    logic [15:0] m_tdata_a, m_tdata_b;
    logic        m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b, m_tuser_a, m_tuser_b;
    logic        ovf_a, ovf_b, align_a, align_b, width_a, width_b, height_a, height_b;
    logic [11:0] lw_a, lw_b, lh_a, lh_b;
    logic [15:0] fc_a, fc_b;

    always #5 pclk = ~pclk;

    dvp_pixel_packer #(
        .MSB_FIRST (1'b1),
        .FIFO_AW   (FIFO_AW),
        .H_PIXELS  (H_PIX),
        .V_LINES   (V_LIN)
    ) u_dut_msb (
        .pclk        (pclk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tdata     (m_tdata_a),
        .m_tvalid    (m_tvalid_a),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast_a),
        .m_tuser     (m_tuser_a),
        .clr_err     (clr_err),
        .overflow    (ovf_a),
        .align_err   (align_a),
        .width_err   (width_a),
        .height_err  (height_a),
        .last_width  (lw_a),
        .last_height (lh_a),
        .frame_cnt   (fc_a)
    );

    dvp_pixel_packer #(
        .MSB_FIRST (1'b0),
        .FIFO_AW   (FIFO_AW),
        .H_PIXELS  (H_PIX),
        .V_LINES   (V_LIN)
    ) u_dut_lsb (
        .pclk        (pclk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tdata     (m_tdata_b),
        .m_tvalid    (m_tvalid_b),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast_b),
        .m_tuser     (m_tuser_b),
        .clr_err     (clr_err),
        .overflow    (ovf_b),
        .align_err   (align_b),
        .width_err   (width_b),
        .height_err  (height_b),
        .last_width  (lw_b),
        .last_height (lh_b),
        .frame_cnt   (fc_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       user;
        logic       last;
        logic [7:0] b0;  // first byte of the pair
        logic [7:0] b1;  // second byte of the pair
    } exp_t;

    exp_t       sbq[$];
    exp_t       head;
    bit         exp_v;
    bit         mon_en = 1'b0;
    int         dut_pops = 0;
    bit         have_first;
    logic [7:0] m_first_byte;
    bit         m_first_user;
    bit         m_first_frame;
    int         m_pix, m_lines, m_last_w, m_last_h, m_frame;
    bit         m_ovf, m_align, m_width, m_height;

    task automatic model_reset();
        sbq.delete();
        have_first    = 1'b0;
        m_first_byte  = 8'h00;
        m_first_user  = 1'b0;
        m_first_frame = 1'b1;
        m_pix = 0; m_lines = 0; m_last_w = 0; m_last_h = 0; m_frame = 0;
        m_ovf = 0; m_align = 0; m_width = 0; m_height = 0;
    endtask

    task automatic model_end_line();
        m_last_w = m_pix;
        if (m_pix != H_PIX) m_width = 1;
        m_pix = 0;
        if (m_lines < 4095) m_lines++;
    endtask

    // Queue size already reflects any pop happening at the coming edge.
    task automatic model_beat(input logic [7:0] b, input bit last, input bit user);
        exp_t e;
        if (user) begin
            if (have_first) m_align = 1;
            m_frame = (m_frame + 1) % 65536;
            if (!m_first_frame) begin
                m_last_h = m_lines;
                if (m_lines != V_LIN) m_height = 1;
            end
            m_first_frame = 0;
            m_lines = 0;
            m_pix = 0;
            have_first = 0;
        end
        if (!have_first) begin
            if (last) begin
                m_align = 1;
                model_end_line();
            end else begin
                have_first   = 1;
                m_first_byte = b;
                m_first_user = user;
            end
        end else begin
            have_first = 0;
            if (m_pix < 4095) m_pix++;
            e.user = m_first_user;
            e.last = last;
            e.b0   = m_first_byte;
            e.b1   = b;
            if (sbq.size() < DEPTH) sbq.push_back(e);
            else m_ovf = 1;
            if (last) model_end_line();
        end
    endtask

    // Per-cycle scoreboard: outputs compared mid-cycle, then the model consumes the
    // inputs the DUT will sample at the next rising edge.
    always @(negedge pclk) begin
        if (mon_en) begin
            exp_v = (sbq.size() != 0);
            check_val("tvalid_msb", 32'(m_tvalid_a), 32'(exp_v));
            check_val("tvalid_lsb", 32'(m_tvalid_b), 32'(exp_v));
            if (exp_v) begin
                head = sbq[0];
                check_val("tdata_msb", 32'(m_tdata_a), {16'h0, head.b0, head.b1});
                check_val("tdata_lsb", 32'(m_tdata_b), {16'h0, head.b1, head.b0});
                check_val("tlast_msb", 32'(m_tlast_a), 32'(head.last));
                check_val("tuser_msb", 32'(m_tuser_a), 32'(head.user));
                check_val("tlast_lsb", 32'(m_tlast_b), 32'(head.last));
                check_val("tuser_lsb", 32'(m_tuser_b), 32'(head.user));
                if (m_tready) void'(sbq.pop_front());
            end
            if (m_tvalid_a && m_tready) dut_pops++;
            check_val("overflow", 32'(ovf_a), 32'(m_ovf));
            check_val("align_err", 32'(align_a), 32'(m_align));
            check_val("width_err", 32'(width_a), 32'(m_width));
            check_val("height_err", 32'(height_a), 32'(m_height));
            check_val("last_width", 32'(lw_a), m_last_w);
            check_val("last_height", 32'(lh_a), m_last_h);
            check_val("frame_cnt", 32'(fc_a), m_frame);
            check_val("frame_cnt_lsb", 32'(fc_b), m_frame);
            if (rst) begin
                model_reset();
            end else begin
                if (clr_err) begin
                    m_ovf = 0; m_align = 0; m_width = 0; m_height = 0;
                end
                if (s_tvalid) model_beat(s_tdata, s_tlast, s_tuser);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_ready = 1'b0;
    bit rnd_gaps  = 1'b0;

    // Drive one byte for exactly one edge; returns 1 time unit after that edge.
    task automatic send(input logic [7:0] b, input bit last, input bit user);
        if (rnd_gaps && ($urandom_range(0, 3) == 0)) begin
            s_tvalid = 1'b0;
            @(posedge pclk); #1;
        end
        if (rnd_ready) m_tready = ($urandom_range(0, 3) != 0);
        s_tdata  = b;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        @(posedge pclk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    task automatic send_line(input int n, input bit sof, input int base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            send(rnd ? 8'($urandom) : 8'(base + i), i == n - 1, sof && (i == 0));
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge pclk); #1;
        clr_err = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge pclk); #1;
        rst = 1'b0;
    endtask

    int pops_before;

    initial begin
        rst      = 1'b1;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        m_tready = 1'b1;
        clr_err  = 1'b0;
        model_reset();
        @(posedge pclk); #1;
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset state
        check_val("rst_tvalid", 32'(m_tvalid_a), 32'd0);
        check_val("rst_tdata", 32'(m_tdata_a), 32'd0);
        check_val("rst_frame_cnt", 32'(fc_a), 32'd0);
        check_val("rst_flags", {28'h0, ovf_a, align_a, width_a, height_a}, 32'd0);

        // 1/2: 4 lines x 8 bytes, bytes 0x00..0x1F, consumer always ready
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 8; i++) begin
                if (l == 0 && i == 2) begin
                    check_val("first_pix_msb", 32'(m_tdata_a), 32'h0001);
                    check_val("first_pix_lsb", 32'(m_tdata_b), 32'h0100);
                    check_val("first_pix_tuser", 32'(m_tuser_a), 32'd1);
                end
                send(8'(l * 8 + i), i == 7, (l == 0) && (i == 0));
            end
        end
        idle(3);
        check_val("t1_last_width", 32'(lw_a), 32'd4);
        check_val("t1_width_err", 32'(width_a), 32'd0);
        check_val("t1_align_err", 32'(align_a), 32'd0);

        // 3: odd-length line, lone final byte dropped
        send_line(7, 1'b0, 8'h40, 1'b0);
        check_val("t3_align_err", 32'(align_a), 32'd1);
        check_val("t3_last_width", 32'(lw_a), 32'd3);
        idle(3);
        pulse_clr();
        check_val("t3_align_clr", 32'(align_a), 32'd0);

        // 4: consumer stalled for 10 pixels
        m_tready = 1'b0;
        send_line(20, 1'b0, 0, 1'b1);
        check_val("t4_overflow", 32'(ovf_a), 32'd1);
        check_val("t4_overflow_lsb", 32'(ovf_b), 32'd1);
        pops_before = dut_pops;
        m_tready = 1'b1;
        idle(10);
        check_val("t4_pops", dut_pops - pops_before, 32'd4);
        check_val("t4_drained", 32'(m_tvalid_a), 32'd0);
        pulse_clr();
        check_val("t4_overflow_clr", 32'(ovf_a), 32'd0);

        // 5: frame of 3 lines, frame of 2 lines, then a third SOF
        pulse_rst();
        send_line(8, 1'b1, 0, 1'b1);
        send_line(8, 1'b0, 0, 1'b1);
        send_line(8, 1'b0, 0, 1'b1);
        send_line(8, 1'b1, 0, 1'b1);
        check_val("t5_height_err_f1", 32'(height_a), 32'd0);
        check_val("t5_last_height_f1", 32'(lh_a), 32'd3);
        send_line(8, 1'b0, 0, 1'b1);
        send_line(8, 1'b1, 0, 1'b1);
        check_val("t5_last_height", 32'(lh_a), 32'd2);
        check_val("t5_height_err", 32'(height_a), 32'd1);
        check_val("t5_frame_cnt", 32'(fc_a), 32'd3);
        idle(4);

        // 6: reset mid-line with the FIFO half full
        m_tready = 1'b0;
        send(8'hA0, 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) send(8'(8'hA0 + i), 1'b0, 1'b0);
        check_val("t6_half_full", 32'(m_tvalid_a), 32'd1);
        pulse_rst();
        check_val("t6_tvalid", 32'(m_tvalid_a), 32'd0);
        check_val("t6_flags", {28'h0, ovf_a, align_a, width_a, height_a}, 32'd0);
        check_val("t6_counters", {8'h0, lw_a, lh_a}, 32'd0);
        check_val("t6_frame_cnt", 32'(fc_a), 32'd0);
        m_tready = 1'b1;
        send_line(8, 1'b0, 0, 1'b0);
        send_line(8, 1'b1, 8'h10, 1'b0);
        check_val("t6_no_height_chk", 32'(height_a), 32'd0);
        check_val("t6_frame_cnt1", 32'(fc_a), 32'd1);
        idle(4);

        // 7: random lines, random SOF/odd lengths, random backpressure and gaps
        rnd_ready = 1'b1;
        rnd_gaps  = 1'b1;
        for (int l = 0; l < 250; l++) begin
            if ($urandom_range(0, 9) == 0) pulse_clr();
            send_line($urandom_range(1, 12), $urandom_range(0, 5) == 0, 0, 1'b1);
        end
        rnd_ready = 1'b0;
        rnd_gaps  = 1'b0;
        m_tready  = 1'b1;
        idle(10);
        check_val("t7_drained", sbq.size(), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
